// File: rtl/pong_game_ctrl.sv
// Pong game control: new-game/play/new-ball/over sequencing, BCD score, ball count, pause timer.
// Optional macro SCORE_SATURATE_EN: score holds at 99 instead of wrapping to 00.
//
// state   | meaning
// NEWGAME | rule text shown, graphics frozen, waiting for a button
// PLAY    | ball in motion, hits score, misses end the round
// NEWBALL | pause after a miss, button restarts once the timer expires
// OVER    | game over text shown for the pause, then back to NEWGAME
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic       graph_still,
  output logic       show_rule,
  output logic       show_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_INIT = BALLS[1:0];
  localparam logic [6:0] TIMER_INIT = TIMER_TICKS[6:0];

  state_t     state_q, state_d;
  logic [6:0] timer_q, timer_d, timer_dec;
  logic [3:0] dig0_q, dig1_q, dig0_d, dig1_d;
  logic [3:0] dig0_inc, dig1_inc;
  logic [1:0] ball_q, ball_d;
  logic       graph_still_q, show_rule_q, show_over_q;
  logic       pressed;

  assign pressed = |btn;

  // Pause timer saturates at zero rather than wrapping.
  always_comb begin
    timer_dec = timer_q;
    if (refresh_tick && (timer_q != 7'd0)) timer_dec = timer_q - 7'd1;
  end

  always_comb begin
    dig0_inc = dig0_q + 4'd1;
    dig1_inc = dig1_q;
    if (dig0_q == 4'd9) begin
      if (dig1_q == 4'd9) begin
`ifdef SCORE_SATURATE_EN
        dig0_inc = 4'd9;
        dig1_inc = 4'd9;
`else
        dig0_inc = 4'd0;
        dig1_inc = 4'd0;
`endif
      end else begin
        dig0_inc = 4'd0;
        dig1_inc = dig1_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dig0_d  = dig0_q;
    dig1_d  = dig1_q;
    ball_d  = ball_q;
    case (state_q)
      NEWGAME: begin
        if (pressed) begin
          state_d = PLAY;
          ball_d  = ball_q - 2'd1;
        end
      end
      PLAY: begin
        if (hit) begin
          dig0_d = dig0_inc;
          dig1_d = dig1_inc;
        end
        if (miss) begin
          timer_d = TIMER_INIT;
          if (ball_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = NEWBALL;
            ball_d  = ball_q - 2'd1;
          end
        end
      end
      NEWBALL: begin
        // A held button is accepted on the same edge the timer reaches zero.
        timer_d = timer_dec;
        if ((timer_dec == 7'd0) && pressed) state_d = PLAY;
      end
      OVER: begin
        timer_d = timer_dec;
        if (timer_dec == 7'd0) begin
          state_d = NEWGAME;
          dig0_d  = 4'd0;
          dig1_d  = 4'd0;
          ball_d  = BALLS_INIT;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= NEWGAME;
      timer_q       <= 7'd0;
      dig0_q        <= 4'd0;
      dig1_q        <= 4'd0;
      ball_q        <= BALLS_INIT;
      graph_still_q <= 1'b1;
      show_rule_q   <= 1'b1;
      show_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      dig0_q        <= dig0_d;
      dig1_q        <= dig1_d;
      ball_q        <= ball_d;
      graph_still_q <= (state_d != PLAY);
      show_rule_q   <= (state_d == NEWGAME);
      show_over_q   <= (state_d == OVER);
    end
  end

  assign dig0        = dig0_q;
  assign dig1        = dig1_q;
  assign ball        = ball_q;
  assign graph_still = graph_still_q;
  assign show_rule   = show_rule_q;
  assign show_over   = show_over_q;
  assign state       = state_q;

endmodule
